// File: rtl/game_state_ctl_if.sv
// Signal bundle between the match controller and its surroundings.
// frame_tick is a one-cycle pulse, start_btn a synchronised level, scores and all outputs are plain registered levels.
interface game_state_ctl_if;
    logic       frame_tick;
    logic       start_btn;
    logic [3:0] player_1_score;
    logic [3:0] player_2_score;
    logic [1:0] game_state;
    logic       ball_rst;
    logic       goal_flag;
    logic [1:0] last_scorer;
    logic [1:0] winner;
    logic [3:0] disp_score_1;
    logic [3:0] disp_score_2;

    modport master (
        output frame_tick, start_btn, player_1_score, player_2_score,
        input  game_state, ball_rst, goal_flag, last_scorer, winner,
               disp_score_1, disp_score_2
    );

    modport slave (
        input  frame_tick, start_btn, player_1_score, player_2_score,
        output game_state, ball_rst, goal_flag, last_scorer, winner,
               disp_score_1, disp_score_2
    );
endinterface

// File: rtl/game_state_ctl.sv
// Match-level controller: detects goals from score changes, runs IDLE/PLAY/GOAL/OVER,
// drives the ball controller reset and latches display scores and banner flags.
module game_state_ctl #(
    parameter int unsigned WIN_SCORE        = 7,
    parameter int unsigned GOAL_HOLD_FRAMES = 120
) (
    input  logic             clk_in,
    input  logic             rst,
    game_state_ctl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GOAL = 2'd2,
        OVER = 2'd3
    } state_t;

    localparam logic [3:0] WIN  = 4'(WIN_SCORE);
    localparam logic [7:0] HOLD = 8'(GOAL_HOLD_FRAMES);

    state_t     state_q, state_d;
    logic       ball_rst_q, ball_rst_d;
    logic       goal_flag_q, goal_flag_d;
    logic [1:0] last_q, last_d;
    logic [1:0] winner_q, winner_d;
    logic [3:0] disp1_q, disp1_d;
    logic [3:0] disp2_q, disp2_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] prev1_q, prev2_q;
    logic       btn_prev_q;

    logic start_edge, ev1, ev2;

    assign start_edge = bus.start_btn & ~btn_prev_q;
    assign ev1        = (bus.player_1_score != prev1_q);
    assign ev2        = (bus.player_2_score != prev2_q);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ball_rst_q  <= 1'b1;
            goal_flag_q <= 1'b0;
            last_q      <= 2'd0;
            winner_q    <= 2'd0;
            disp1_q     <= 4'd0;
            disp2_q     <= 4'd0;
            cnt_q       <= 8'd0;
            prev1_q     <= 4'd0;
            prev2_q     <= 4'd0;
            // Held high so a button already pressed through reset cannot start a match.
            btn_prev_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            ball_rst_q  <= ball_rst_d;
            goal_flag_q <= goal_flag_d;
            last_q      <= last_d;
            winner_q    <= winner_d;
            disp1_q     <= disp1_d;
            disp2_q     <= disp2_d;
            cnt_q       <= cnt_d;
            prev1_q     <= bus.player_1_score;
            prev2_q     <= bus.player_2_score;
            btn_prev_q  <= bus.start_btn;
        end
    end

    always_comb begin
        state_d     = state_q;
        ball_rst_d  = ball_rst_q;
        goal_flag_d = goal_flag_q;
        last_d      = last_q;
        winner_d    = winner_q;
        disp1_d     = disp1_q;
        disp2_d     = disp2_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                ball_rst_d  = 1'b1;
                goal_flag_d = 1'b0;
                disp1_d     = 4'd0;
                disp2_d     = 4'd0;
                if (start_edge) begin
                    state_d    = PLAY;
                    ball_rst_d = 1'b0;
                    last_d     = 2'd0;
                    winner_d   = 2'd0;
                end
            end
            PLAY, GOAL: begin
                ball_rst_d = 1'b0;
                disp1_d    = bus.player_1_score;
                disp2_d    = bus.player_2_score;
                // A goal outranks a frame tick arriving in the same cycle.
                if (ev1 || ev2) begin
                    last_d = ev1 ? 2'd1 : 2'd2;
                    if (bus.player_1_score >= WIN) begin
                        state_d     = OVER;
                        winner_d    = 2'd1;
                        ball_rst_d  = 1'b1;
                        goal_flag_d = 1'b0;
                        cnt_d       = 8'd0;
                    end else if (bus.player_2_score >= WIN) begin
                        state_d     = OVER;
                        winner_d    = 2'd2;
                        ball_rst_d  = 1'b1;
                        goal_flag_d = 1'b0;
                        cnt_d       = 8'd0;
                    end else begin
                        state_d     = GOAL;
                        goal_flag_d = 1'b1;
                        cnt_d       = HOLD;
                    end
                end else if (state_q == GOAL && bus.frame_tick && cnt_q != 8'd0) begin
                    if (cnt_q == 8'd1) begin
                        state_d     = PLAY;
                        goal_flag_d = 1'b0;
                        cnt_d       = 8'd0;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            OVER: begin
                ball_rst_d  = 1'b1;
                goal_flag_d = 1'b0;
                if (start_edge) begin
                    state_d    = PLAY;
                    ball_rst_d = 1'b0;
                    winner_d   = 2'd0;
                    last_d     = 2'd0;
                    disp1_d    = 4'd0;
                    disp2_d    = 4'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.game_state   = state_q;
    assign bus.ball_rst     = ball_rst_q;
    assign bus.goal_flag    = goal_flag_q;
    assign bus.last_scorer  = last_q;
    assign bus.winner       = winner_q;
    assign bus.disp_score_1 = disp1_q;
    assign bus.disp_score_2 = disp2_q;
endmodule

// File: doc/game_state_ctl.md
# game_state_ctl

Match-level controller that sits directly downstream of the ball controller. It watches the ball controller's two 4-bit score outputs and detects each goal. It runs an IDLE / PLAY / GOAL / OVER state machine and drives the ball controller's reset input to start and end matches. It also latches the scores for display, so they survive that reset, and exposes banner flags to the renderer.

## Interface
- WIN_SCORE, 7, score that ends the match; legal range 1..15
- GOAL_HOLD_FRAMES, 120, frame ticks the GOAL banner stays up; legal range 1..255

Ports:
- clk_in  in  1  system clock; every register is on its rising edge
- rst  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- start_btn  in  1  start/restart request, level, already synchronised to clk_in
- player_1_score  in  4  score from the ball controller
- player_2_score  in  4  score from the ball controller
- game_state  out  2  0=IDLE, 1=PLAY, 2=GOAL, 3=OVER
- ball_rst  out  1  drives the ball controller's rst
- goal_flag  out  1  high while in GOAL
- last_scorer  out  2  0=none, 1=player 1, 2=player 2
- winner  out  2  0=none, 1=player 1, 2=player 2
- disp_score_1  out  4  player 1 score shown on screen
- disp_score_2  out  4  player 2 score shown on screen

## Operation
- Reset values: game_state=IDLE, ball_rst=1, goal_flag=0, last_scorer=0, winner=0, disp scores=0, goal counter=0.
- Internal prev_score_1 and prev_score_2 reset to 0.
- Internal btn_prev resets to 1, so a button held through reset does not start a game.
- Start edge: start_btn=1 while btn_prev=0.
- Goal events:
  - ev1 = (player_1_score != prev_score_1); ev2 = (player_2_score != prev_score_2).
  - The prev registers copy the inputs every cycle in every state.
  - Events are acted on only in PLAY and GOAL.
- IDLE:
  - ball_rst=1, disp scores=0.
  - Start edge → PLAY.
- PLAY:
  - ball_rst=0; disp scores take the inputs each cycle.
  - Any event → set last_scorer (player 1 wins priority if ev1 and ev2 occur together).
  - Then, if player_1_score ≥ WIN_SCORE → OVER with winner=1.
  - Else if player_2_score ≥ WIN_SCORE → OVER with winner=2.
  - Else → GOAL, with the counter loaded to GOAL_HOLD_FRAMES.
- GOAL:
  - goal_flag=1, ball_rst=0; disp scores keep tracking the inputs.
  - frame_tick decrements the counter; frame_tick while counter==1 → PLAY, goal_flag=0.
  - A new event in GOAL is handled exactly as in PLAY: a win goes to OVER; otherwise the counter reloads and last_scorer updates.
  - An event takes priority over frame_tick in the same cycle.
- OVER:
  - ball_rst=1; disp scores and winner are frozen at their entry values, even though the ball controller's scores clear to 0.
  - Start edge → PLAY, clearing winner, last_scorer and disp scores.
- start_btn is ignored in PLAY and GOAL.
- Scores never wrap inside this block: WIN_SCORE ≤ 15 guarantees the ball controller's 4-bit score stops before wrapping.
- Counter is 8 bits and never underflows: decrements happen only while it is ≥ 1.

## Timing
- All outputs are registered; no combinational path from input to output.
- Start edge sampled at cycle t → game_state=PLAY and ball_rst=0 at t+1.
- Score input changes at cycle t → ev seen at t → state, last_scorer and winner update at t+1.
- disp_score_n follows player_n_score with 1 cycle latency in PLAY and GOAL.
- GOAL lasts exactly GOAL_HOLD_FRAMES frame_tick pulses after entry. A frame_tick in the entry cycle itself is not counted.
- Asynchronous rst assertion mid-match forces all reset values immediately, including ball_rst=1. Release returns to IDLE.

## Test plan
- Reset with start_btn held high, then release rst → stays IDLE with ball_rst=1; releasing and re-pressing start → PLAY one cycle after the edge, ball_rst=0.
- In PLAY, step player_1_score 0→1 → next cycle: GOAL, last_scorer=1, disp_score_1=1. With GOAL_HOLD_FRAMES=3, three frame_tick pulses → PLAY on the cycle after the third.
- In GOAL, step player_2_score 0→1 on the same cycle as a frame_tick → counter reloads to 3, last_scorer=2; three more ticks are needed to reach PLAY.
- WIN_SCORE=7: drive player_2_score 6→7 in PLAY → OVER, winner=2, ball_rst=1. Then drive both inputs to 0 → disp scores stay at their latched values, e.g. 3 and 7.
- In OVER, press start → PLAY, with winner=0, last_scorer=0, disp scores=0, ball_rst=0.
- Assert rst asynchronously mid-GOAL, between clock edges → outputs go to reset values before the next clk_in edge.
